life_grid_dump: RTL

//  Read-side companion to life_array_4x4. Snapshots the array's alive vector
//  and streams it out as ASCII text frames over a valid/ready byte interface,
//  e.g. toward a UART transmitter. Cells print as 'X'/'o', one text line per

---
 rtl/life_pkg.sv | 32 +++
 rtl/life_grid_dump.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
//   Definitions shared by the Game-of-Life grid, its writer path and the
//   text dump reader.
//   - GRID_ROWS / GRID_COLS : default grid dimensions
//   - CHAR_*                : ASCII bytes used when printing a grid
//   - dump_state_e          : state encoding of the dump FSM
//   - cell_index()          : maps (row, col) to a bit of the flat alive vector
// ---------------------------------------------------------------------------
package life_pkg;

  localparam int GRID_ROWS = 4;
  localparam int GRID_COLS = 4;

  localparam logic [7:0] CHAR_LIVE = 8'h58;  // 'X'
  localparam logic [7:0] CHAR_DEAD = 8'h6F;  // 'o'
  localparam logic [7:0] CHAR_EOL  = 8'h0A;  // '\n'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CELL = 2'd1,
    ST_EOL  = 2'd2,
    ST_TRL  = 2'd3
  } dump_state_e;

  // Column-major packing: the array stores all rows of column 0 first.
  // The writer path and life_array_4x4 use exactly the same mapping.
  function automatic int cell_index(input int r, input int c, input int rows);
    return rows * c + r;
  endfunction

endpackage

// File: rtl/life_grid_dump.sv
// ---------------------------------------------------------------------------
// life_grid_dump
//   Snapshots the alive vector of the Life array and streams it out as an
//   ASCII text frame over a valid/ready byte interface (e.g. into a UART
//   transmitter). Each grid row prints as COLS cell characters followed by an
//   end-of-line byte; with TRAILER=1 an extra end-of-line closes the frame.
//
//   Ports
//     clk       : rising-edge clock
//     reset_n   : asynchronous active-low reset
//     alive     : live vector, cell(r,c) = alive[ROWS*c + r]
//     gen_tick  : one-cycle pulse per generation step
//     auto_en   : when 1, gen_tick also requests a dump
//     dump_req  : one-cycle explicit dump request
//     tx_data   : output byte
//     tx_valid  : tx_data is valid
//     tx_ready  : sink accepts the byte on tx_valid && tx_ready
//     busy      : a frame is in progress
//     drop_cnt  : saturating count of requests that could not be queued
// ---------------------------------------------------------------------------
module life_grid_dump
  import life_pkg::*;
#(
  parameter int         ROWS      = GRID_ROWS,
  parameter int         COLS      = GRID_COLS,
  parameter logic [7:0] CHAR_LIVE = life_pkg::CHAR_LIVE,
  parameter logic [7:0] CHAR_DEAD = life_pkg::CHAR_DEAD,
  parameter logic [7:0] CHAR_EOL  = life_pkg::CHAR_EOL,
  parameter int         TRAILER   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ROWS*COLS-1:0] alive,
  input  logic                 gen_tick,
  input  logic                 auto_en,
  input  logic                 dump_req,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  dump_state_e          state_q, state_d;
  logic [ROWS*COLS-1:0] snap_q, snap_d;
  logic [RW-1:0]        r_q, r_d;
  logic [CW-1:0]        c_q, c_d;
  logic                 pending_q, pending_d;
  logic [7:0]           drop_q, drop_d;

  logic          req;
  logic          hs;
  logic          last_byte;
  logic          start;
  logic [IW-1:0] cell_idx;
  logic          cell_bit;

  assign req      = dump_req | (auto_en & gen_tick);
  assign tx_valid = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = drop_q;
  assign hs       = tx_valid & tx_ready;

  assign cell_idx = IW'(cell_index(int'(r_q), int'(c_q), ROWS));
  assign cell_bit = snap_q[cell_idx];

  // The final byte of a frame is either the trailer or, without a trailer,
  // the end-of-line of the last row. Its handshake is where a queued frame
  // may start back-to-back.
  assign last_byte = hs &&
                     ((state_q == ST_TRL) ||
                      ((state_q == ST_EOL) && (r_q == R_LAST) && (TRAILER == 0)));

  // State register. Reset abandons any frame in flight immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      pending_q <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      r_q       <= r_d;
      c_q       <= c_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state and byte selection. The frame walker advances only on a
  // handshake, so tx_data stays stable while the sink stalls. Request
  // queueing is resolved afterwards and may override the walker with a
  // fresh frame start.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    r_d       = r_q;
    c_d       = c_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    tx_data   = 8'h00;
    start     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          start = 1'b1;
        end
      end
      ST_CELL: begin
        tx_data = cell_bit ? CHAR_LIVE : CHAR_DEAD;
        if (hs) begin
          if (c_q == C_LAST) begin
            state_d = ST_EOL;
          end else begin
            c_d = c_q + C_ONE;
          end
        end
      end
      ST_EOL: begin
        tx_data = CHAR_EOL;
        if (hs) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            state_d = (TRAILER != 0) ? ST_TRL : ST_IDLE;
          end else begin
            r_d     = r_q + R_ONE;
            state_d = ST_CELL;
          end
        end
      end
      ST_TRL: begin
        tx_data = CHAR_EOL;
        if (hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While busy a request is queued one deep; beyond that it is counted
    // as dropped. On the final handshake a queued request (or one arriving
    // on that very edge) restarts the walker with no idle gap. If both are
    // present the queued one starts and the new one takes its slot.
    if (state_q != ST_IDLE) begin
      if (last_byte) begin
        if (pending_q) begin
          start     = 1'b1;
          pending_d = req;
        end else if (req) begin
          start = 1'b1;
        end
      end else if (req) begin
        if (pending_q) begin
          if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end else begin
          pending_d = 1'b1;
        end
      end
    end

    if (start) begin
      snap_d  = alive;
      r_d     = '0;
      c_d     = '0;
      state_d = ST_CELL;
    end
  end

endmodule
